// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the serial pattern match controller.
package seq_match_pkg;

    localparam int LEN_W  = 4;
    localparam int MASK_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ones in the low 'len' bit positions; len = 15 yields all ones.
    function automatic logic [MASK_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        return MASK_W'((16'(1) << len) - 16'(1));
    endfunction

endpackage

// File: rtl/seq_match_if.sv
// Configuration, control and serial data bundle between host and match controller.
interface seq_match_if #(
    parameter int MAXLEN = 8,
    parameter int CNT_W  = 8
);
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic [MAXLEN-1:0]               cfg_pattern;
    logic [seq_match_pkg::LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0]                cfg_target;
    logic                            cfg_err;
    logic                            start;
    logic                            abort;
    logic                            data_valid;
    logic                            data;
    logic                            match;
    logic [CNT_W-1:0]                match_cnt;
    logic                            busy;
    logic                            done;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, data_valid, data,
        input  cfg_ready, cfg_err, match, match_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, data_valid, data,
        output cfg_ready, cfg_err, match, match_cnt, busy, done
    );
endinterface

// File: rtl/seq_shift_match.sv
// Serial history register with fill tracking and a length-masked pattern compare.
module seq_shift_match
    import seq_match_pkg::*;
#(
    parameter int MAXLEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_bit,
    input  logic [MAXLEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_hit
);

    // Only MAXLEN-1 bits need storing: the compare window includes the incoming bit.
    logic [MAXLEN-2:0] r_hist;
    logic [LEN_W-1:0]  r_fill;

    logic [MAXLEN-1:0] w_hist_next;
    logic [MAXLEN-1:0] w_mask;
    logic [LEN_W:0]    w_fill_inc;
    logic              w_full;

    assign w_hist_next = {r_hist, i_bit};
    assign w_mask      = MAXLEN'(len_mask(i_len));
    assign w_fill_inc  = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_full      = (w_fill_inc >= {1'b0, i_len});
    assign o_hit       = i_en && w_full && (((w_hist_next ^ i_pattern) & w_mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_en) begin
            r_hist <= w_hist_next[MAXLEN-2:0];
            r_fill <= w_full ? i_len : w_fill_inc[LEN_W-1:0];
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Reconfigurable serial pattern match controller: config latch, run FSM, match counter.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int MAXLEN = 8,
    parameter int CNT_W  = 8
) (
    input logic        clk,
    input logic        rst,
    seq_match_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MAXLEN-1:0] r_pattern;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_target;
    logic              r_cfg_ok;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_match;
    logic              r_cfg_err;
    logic              r_cfg_ready;
    logic              r_busy;
    logic              r_done;

    logic              w_run;
    logic              w_cfg_hs;
    logic              w_len_ok;
    logic              w_sh_en;
    logic              w_arm;
    logic              w_hit;
    logic              w_final;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_ready_nxt;
    logic              w_err_nxt;

    assign w_run     = (r_state == ST_RUN);
    assign w_cfg_hs  = bus.cfg_valid && !w_run;
    assign w_len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAXLEN));
    // Abort suppresses the shift so a completing bit cannot produce a match.
    assign w_sh_en   = w_run && bus.data_valid && !bus.abort;
    assign w_arm     = !w_run && (w_state_nxt == ST_RUN);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_final   = w_hit && (r_target != '0) && (w_cnt_inc == r_target);

    seq_shift_match #(
        .MAXLEN (MAXLEN)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_sh_en),
        .i_clr     (w_arm),
        .i_bit     (bus.data),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A config handshake takes priority over start; abort overrides both.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.abort || w_cfg_hs)       w_state_nxt = ST_IDLE;
                else if (bus.start && r_cfg_ok)  w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort)    w_state_nxt = ST_IDLE;
                else if (w_final) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt  = (w_state_nxt == ST_RUN);
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_ready_nxt = (w_state_nxt != ST_RUN);
        w_err_nxt   = w_cfg_hs && !w_len_ok;
        w_cnt_nxt   = r_cnt;
        if (w_arm)      w_cnt_nxt = '0;
        else if (w_hit) w_cnt_nxt = w_cnt_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_match     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_match     <= w_hit;
            r_cfg_err   <= w_err_nxt;
            r_cfg_ready <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_target  <= '0;
            r_cfg_ok  <= 1'b0;
        end else if (w_cfg_hs && w_len_ok) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= bus.cfg_len;
            r_target  <= bus.cfg_target;
            r_cfg_ok  <= 1'b1;
        end
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.match     = r_match;
    assign bus.match_cnt = r_cnt;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: directed scenarios plus randomized traffic vs a queue-based model.
module tb_seq_match_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_match_if #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) bus ();

    seq_match_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cnt;
        bit done;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_seen = 0;

    // Reference model: run flags, stored configuration and the bits received this run.
    bit              m_cfg_ok;
    bit              m_running;
    bit              m_done;
    bit              m_err;
    bit [MAXLEN-1:0] m_pat;
    int              m_len;
    int              m_tgt;
    int              m_cnt;
    bit              m_bits[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit model_hit();
        int n = m_bits.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (m_bits[n-1-i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_cfg_ok  = 0;
        m_running = 0;
        m_done    = 0;
        m_err     = 0;
        m_pat     = '0;
        m_len     = 0;
        m_tgt     = 0;
        m_cnt     = 0;
        m_bits.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_done"},      bus.done,      0);
        chk({tag, "_match"},     bus.match,     0);
        chk({tag, "_cfg_err"},   bus.cfg_err,   0);
        chk({tag, "_match_cnt"}, bus.match_cnt, 0);
    endtask

    // One clock of stimulus: predict, apply, then check the registered state just after the edge.
    task automatic step(input bit cv, input logic [MAXLEN-1:0] pat, input int len, input int tgt,
                        input bit st, input bit ab, input bit dv, input bit d);
        int pushed = 0;
        bit ready;
        bit hs;
        bus.cfg_valid   = cv;
        bus.cfg_pattern = pat;
        bus.cfg_len     = 4'(len);
        bus.cfg_target  = CNT_W'(tgt);
        bus.start       = st;
        bus.abort       = ab;
        bus.data_valid  = dv;
        bus.data        = d;

        ready = !m_running;
        hs    = cv && ready;
        m_err = 0;
        if (hs) begin
            if (len >= 1 && len <= MAXLEN) begin
                m_pat    = pat;
                m_len    = len;
                m_tgt    = tgt;
                m_cfg_ok = 1;
            end else begin
                m_err = 1;
            end
        end
        if (ab) begin
            m_running = 0;
            m_done    = 0;
        end else if (hs) begin
            m_done = 0;
        end else if (ready && st && m_cfg_ok) begin
            m_running = 1;
            m_done    = 0;
            m_cnt     = 0;
            m_bits.delete();
        end else if (m_running && dv) begin
            m_bits.push_back(d);
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            if (model_hit()) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_tgt != 0 && m_cnt == m_tgt) begin
                    m_running = 0;
                    m_done    = 1;
                end
                sb_q.push_back('{cnt: m_cnt, done: m_done});
                pushed = 1;
            end
        end

        @(posedge clk);
        #2;
        chk("busy",       bus.busy,      m_running);
        chk("done",       bus.done,      m_done);
        chk("cfg_ready",  bus.cfg_ready, !m_running);
        chk("cfg_err",    bus.cfg_err,   m_err);
        chk("match_cnt",  bus.match_cnt, m_cnt);
        chk("sb_pending", sb_q.size(),   pushed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic [MAXLEN-1:0] pat, input int len, input int tgt);
        step(1, pat, len, tgt, 0, 0, 0, 0);
    endtask

    task automatic go();
        step(0, '0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic bit_in(input bit d);
        step(0, '0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic abort_now();
        step(0, '0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.match === 1'b1) begin
                n_seen++;
                if (sb_q.size() == 0) begin
                    chk("match_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("match_cnt_at_match", bus.match_cnt, e.cnt);
                    chk("done_at_match",      bus.done,      e.done);
                    chk("busy_at_match",      bus.busy,      !e.done);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        bus.cfg_valid   = 0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_target  = '0;
        bus.start       = 0;
        bus.abort       = 0;
        bus.data_valid  = 0;
        bus.data        = 0;
        model_reset();

        #1 rst = 1'b1;
        #2 chk_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Start with no legal configuration is ignored.
        go();
        idle(1);

        // 1011 / len 4 / target 2 over 1,0,1,1,0,1,1.
        base = n_seen;
        cfg(8'b1011, 4, 2);
        go();
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("t1_cnt_after_bit4", bus.match_cnt, 1);
        bit_in(0); bit_in(1); bit_in(1);
        chk("t1_done", bus.done, 1);
        chk("t1_busy", bus.busy, 0);
        idle(1);
        chk("t1_match_count", n_seen - base, 2);

        // Illegal lengths in DONE: error pulse, return to IDLE, previous config kept.
        cfg(8'b0000_0110, 0, 3);
        chk("t2_err_len0", bus.cfg_err, 1);
        cfg(8'b0000_0110, 9, 3);
        chk("t2_err_len9", bus.cfg_err, 1);
        idle(1);
        base = n_seen;
        go();
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        idle(1);
        chk("t2_retained_cfg", n_seen - base, 1);
        abort_now();

        // 11 / len 2 / unlimited, valid toggling.
        base = n_seen;
        cfg(8'b11, 2, 0);
        go();
        for (int i = 0; i < 8; i++) begin
            bit_in(1);
            idle(1);
        end
        chk("t3_match_count", n_seen - base, 7);
        chk("t3_done", bus.done, 0);
        abort_now();

        // Abort on the completing bit of 101.
        cfg(8'b101, 3, 0);
        go();
        bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        base = n_seen;
        step(0, '0, 0, 0, 0, 1, 1, 1);
        idle(1);
        chk("t4_no_match", n_seen - base, 0);
        chk("t4_cnt_held", bus.match_cnt, 1);
        chk("t4_busy", bus.busy, 0);

        // Config plus start together in DONE.
        cfg(8'b1, 1, 1);
        go();
        bit_in(1);
        chk("t5_done", bus.done, 1);
        step(1, 8'b110, 3, 1, 1, 0, 0, 0);
        chk("t5_idle_busy", bus.busy, 0);
        chk("t5_idle_done", bus.done, 0);
        go();
        chk("t5_cnt_cleared", bus.match_cnt, 0);
        bit_in(1); bit_in(1); bit_in(0);
        chk("t5_new_pattern_done", bus.done, 1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            bit              r_cv;
            logic [MAXLEN-1:0] r_pat;
            int              r_len;
            r_cv  = ($urandom_range(0, 9) == 0);
            r_pat = MAXLEN'($urandom);
            r_len = ($urandom_range(0, 4) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 15);
            step(r_cv, r_pat, r_len, $urandom_range(0, 4),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        abort_now();

        // Reset mid-run after 2 of 4 bits.
        cfg(8'b1001, 4, 0);
        go();
        bit_in(1); bit_in(0);
        rst = 1'b1;
        #1 chk_reset_vals("midrun");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        go();
        chk("post_rst_start_ignored", bus.busy, 0);
        cfg(8'b1001, 4, 0);
        go();
        chk("post_rst_reconfig_runs", bus.busy, 1);
        abort_now();
        idle(2);

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial-pattern match controller. Accepts a bit pattern, length and target match count over a configuration handshake. It arms on `start`, scans a qualified serial bit stream for overlapping occurrences of the pattern, and counts matches. When the target count is reached it stops and reports `done`. It sits between the host/config logic and the serial data path, replacing fixed-pattern detectors with one sequenced, reconfigurable block.

## Interface
Parameters:
- `MAXLEN`, 8: maximum pattern length in bits (2..15).
- `CNT_W`, 8: width of the match counter and the target count.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_valid`, in, 1: configuration offer.
- `cfg_ready`, out, 1: high in IDLE and DONE.
- `cfg_pattern`, in, MAXLEN: pattern. Bit `[len-1]` is the first bit received.
- `cfg_len`, in, 4: pattern length. Legal range is 1..MAXLEN.
- `cfg_target`, in, CNT_W: number of matches to stop at. 0 means unlimited.
- `cfg_err`, out, 1: one-cycle pulse when an illegal `cfg_len` is rejected.
- `start`, in, 1: arm the detector. Honoured only in IDLE/DONE with a valid configuration.
- `abort`, in, 1: return to IDLE from any state.
- `data_valid`, in, 1: qualifies `data`.
- `data`, in, 1: serial bit.
- `match`, out, 1: one-cycle pulse per detected occurrence.
- `match_cnt`, out, CNT_W: matches counted in the current run.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.

## Operation
- States:
  - IDLE: `cfg_ready`=1.
  - RUN: scanning.
  - DONE: target reached; `cfg_ready`=1.
- Configuration:
  - A handshake (`cfg_valid & cfg_ready`) with `cfg_len` in 1..MAXLEN latches pattern, length and target, and sets `cfg_ok`.
  - A handshake with an illegal length leaves the stored configuration unchanged and pulses `cfg_err`.
  - A handshake in DONE moves the block to IDLE.
- `start` in IDLE/DONE with `cfg_ok`=1 → RUN. On entry, history, history fill count and `match_cnt` are cleared.
- `start` while `cfg_ok`=0 is ignored.
- In RUN, each `data_valid` cycle:
  - Shifts `data` into the history register at the LSB.
  - Increments the fill count, saturating at `len`.
  - Signals a match when the fill count (including the new bit) is ≥ `len` and the low `len` history bits equal the low `len` pattern bits.
- Overlap is allowed. History is not cleared after a match.
- On a match: `match_cnt` increments. If `cfg_target`≠0 and the new count equals `cfg_target` → DONE.
- With `cfg_target`=0 the run never finishes. `match_cnt` wraps modulo 2^CNT_W.
- `data_valid`=0 cycles freeze history, fill count and state.
- `abort` → IDLE from any state. It clears nothing in the configuration. `match_cnt` holds its value until the next `start`.
- `data`/`data_valid` are ignored outside RUN.
- Simultaneous events:
  - `cfg_valid` and `start` in the same cycle: the configuration is taken and `start` is ignored.
  - `abort` and a matching bit in the same cycle: `abort` wins. No `match` pulse and no count update.
  - `abort` and `start` in the same cycle: `abort` wins.
- Reset values:
  - `cfg_ready`=1 (IDLE).
  - `cfg_err`, `match`, `busy`, `done` = 0.
  - `match_cnt` = 0.
  - Stored configuration cleared; `cfg_ok`=0.
  - Reset mid-run discards the run immediately.

## Timing
- All outputs are registered.
- `match` asserts in the cycle after the `data_valid` cycle carrying the pattern's last bit.
- `match_cnt` shows the new value in the same cycle as `match`.
- The final match: `done`=1 and `busy`=0 in the same cycle as its `match` pulse.
- `start` sampled at edge N → `busy`=1 from cycle N+1. A bit presented with `data_valid` in cycle N+1 is the first bit scanned.
- `cfg_err` pulses in the cycle after the rejected handshake.
- `abort` at edge N → `busy`/`done`=0 from cycle N+1.
- Minimum spacing between `match` pulses is one cycle (consecutive matches possible for `len`=1).

## Structure
- Package `seq_match_pkg`:
  - State enum (IDLE, RUN, DONE).
  - LEN_W constant (4).
  - Helper function that produces a length mask from `len`.
- Sub-module `seq_shift_match`:
  - History shift register, fill counter and masked compare.
  - Inputs: shift enable, clear, bit, pattern, length.
  - Output: combinational match flag to the controller FSM.
- The controller owns the configuration registers, FSM, counter and output registers.

## Test plan
- Configure pattern 4'b1011, len 4, target 2. Start, then stream 1,0,1,1,0,1,1 on consecutive valid cycles → `match` after bits 4 and 7; `match_cnt`=1 then 2; `done`=1 with the second pulse; `busy`=0.
- Configure len 0 or len 9 (MAXLEN 8) → `cfg_err` pulse; previous configuration retained; `start` with no prior legal configuration is ignored.
- Pattern 2'b11, len 2, target 0. Stream eight 1s with `data_valid` toggling 1,0 → 7 `match` pulses; zero-valid cycles cause no state change; `done` stays 0.
- Assert `abort` in the same cycle as a completing bit (pattern 3'b101) → no `match`; IDLE next cycle; `match_cnt` unchanged.
- `cfg_valid` plus `start` together in DONE → new configuration stored; state IDLE; a subsequent `start` runs with the new pattern and `match_cnt` cleared.
- Assert `rst` mid-RUN after 2 of 4 pattern bits → all outputs at reset values immediately; a `start` after deassertion is ignored until reconfiguration.
